// File: rtl/pl_exception_return.sv
// Exception-entry/return sequencer: latches EPC/Cause, drives a timed flush plus handler redirect, and returns to EPC on ERET.
// Optional double-fault halt is compiled in with `define PL_EXC_DOUBLE_FAULT_EN.
module pl_exception_return #(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        exc_req,
    input  logic [31:0] exc_vector,
    input  logic [31:0] exc_pc,
    input  logic        exc_undef,
    input  logic        exc_ovf,
    input  logic        eret,
    input  logic [1:0]  mfc0_sel,
    output logic [31:0] mfc0_data,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        exl,
    output logic        halted
);

    localparam logic [3:0] FLUSH_INIT = FLUSH_CYCLES[3:0];

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_EXC_FLUSH = 3'd1,
        S_EXC_REDIR = 3'd2,
        S_HANDLER   = 3'd3,
        S_RET_REDIR = 3'd4
`ifdef PL_EXC_DOUBLE_FAULT_EN
        ,
        S_HALT      = 3'd5
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_exl;
    logic        w_exl_next;
    logic        w_accept_exc;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic [31:0] r_vec_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_exl   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_exl   <= w_exl_next;
        end
    end

    // Exception context is only rewritten when an exception is accepted from RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc   <= '0;
            r_cause <= '0;
            r_vec_q <= '0;
        end else if (w_accept_exc) begin
            r_epc   <= exc_pc;
            r_cause <= {30'b0, exc_ovf, exc_undef};
            r_vec_q <= exc_vector;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_exl_next   = r_exl;
        w_accept_exc = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (enable && exc_req) begin
                    w_accept_exc = 1'b1;
                    w_exl_next   = 1'b1;
                    w_cnt_next   = FLUSH_INIT;
                    w_state_next = S_EXC_FLUSH;
                end
            end
            S_EXC_FLUSH: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_EXC_REDIR;
                end
            end
            S_EXC_REDIR: begin
                w_state_next = S_HANDLER;
            end
            S_HANDLER: begin
`ifdef PL_EXC_DOUBLE_FAULT_EN
                if (enable && exc_req) begin
                    w_state_next = S_HALT;
                end else if (enable && eret) begin
                    w_state_next = S_RET_REDIR;
                end
`else
                if (enable && eret) begin
                    w_state_next = S_RET_REDIR;
                end
`endif
            end
            S_RET_REDIR: begin
                w_exl_next   = 1'b0;
                w_state_next = S_RUN;
            end
`ifdef PL_EXC_DOUBLE_FAULT_EN
            S_HALT: begin
                w_state_next = S_HALT;
            end
`endif
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Moore decode of the state register; pc_target reads 0 outside redirect cycles.
    always_comb begin
        flush       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        halted      = 1'b0;
        unique case (r_state)
            S_EXC_FLUSH: begin
                flush = 1'b1;
            end
            S_EXC_REDIR: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = r_vec_q;
            end
            S_RET_REDIR: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = r_epc;
            end
`ifdef PL_EXC_DOUBLE_FAULT_EN
            S_HALT: begin
                flush  = 1'b1;
                halted = 1'b1;
            end
`endif
            default: begin
                flush = 1'b0;
            end
        endcase
    end

    assign exl = r_exl;

    always_comb begin
        mfc0_data = '0;
        unique case (mfc0_sel)
            2'd0:    mfc0_data = {31'b0, r_exl};
            2'd1:    mfc0_data = r_cause;
            2'd2:    mfc0_data = r_epc;
            default: mfc0_data = '0;
        endcase
    end

endmodule
